// File: rtl/clock_display_scan.sv
// Six-digit multiplexed seven-segment driver for a binary hh:mm:ss source.
// Snapshots the time once per scan frame, formats 12/24-hour, and blinks the colon.
module clock_display_scan #(
   parameter int REFRESH_DIV = 50000,
   parameter int CNT_W       = 16
) (
   input  logic       Clk,
   input  logic       Clr,
   input  logic [5:0] H,
   input  logic [5:0] M,
   input  logic [5:0] S,
   input  logic       Mode12,
   input  logic       En,
   output logic [6:0] Seg,
   output logic [5:0] An,
   output logic       Dp
);

   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'b1000000;
         4'd1:    p = 7'b1111001;
         4'd2:    p = 7'b0100100;
         4'd3:    p = 7'b0110000;
         4'd4:    p = 7'b0011001;
         4'd5:    p = 7'b0010010;
         4'd6:    p = 7'b0000010;
         4'd7:    p = 7'b1111000;
         4'd8:    p = 7'b0000000;
         4'd9:    p = 7'b0010000;
         default: p = SEG_BLANK;
      endcase
      return p;
   endfunction

   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_idx;
   logic [5:0]       r_h;
   logic [5:0]       r_m;
   logic [5:0]       r_s;
   logic [6:0]       r_seg;
   logic [5:0]       r_an;
   logic             r_dp;

   logic             w_tc;
   logic             w_s_valid;
   logic             w_m_valid;
   logic             w_h_valid;
   logic             w_pm;
   logic [5:0]       w_h12;
   logic [5:0]       w_h_disp;
   logic [5:0]       w_s_tens, w_s_ones;
   logic [5:0]       w_m_tens, w_m_ones;
   logic [5:0]       w_h_tens, w_h_ones;
   logic [6:0]       w_seg_nxt;
   logic             w_dp_nxt;
   logic             w_colon_n;

   assign w_tc      = (r_cnt == CNT_W'(REFRESH_DIV - 1));
   assign w_s_valid = (r_s <= 6'd59);
   assign w_m_valid = (r_m <= 6'd59);
   assign w_h_valid = (r_h <= 6'd23);
   // An out-of-range hour never reports PM.
   assign w_pm      = w_h_valid && (r_h >= 6'd12);
   assign w_h12     = (r_h == 6'd0) ? 6'd12 : ((r_h > 6'd12) ? (r_h - 6'd12) : r_h);
   assign w_h_disp  = (Mode12 && w_h_valid) ? w_h12 : r_h;
   assign w_s_tens  = r_s / 6'd10;
   assign w_s_ones  = r_s % 6'd10;
   assign w_m_tens  = r_m / 6'd10;
   assign w_m_ones  = r_m % 6'd10;
   assign w_h_tens  = w_h_disp / 6'd10;
   assign w_h_ones  = w_h_disp % 6'd10;
   assign w_colon_n = ~(w_s_valid && (r_s[0] == 1'b0));

   // Select segment pattern and decimal point for the digit currently being scanned.
   always_comb begin
      w_seg_nxt = SEG_BLANK;
      w_dp_nxt  = 1'b1;
      case (r_idx)
         3'd0: begin
            w_seg_nxt = w_s_valid ? seg7(w_s_ones[3:0]) : SEG_DASH;
            w_dp_nxt  = ~(Mode12 && w_pm);
         end
         3'd1: w_seg_nxt = w_s_valid ? seg7(w_s_tens[3:0]) : SEG_DASH;
         3'd2: begin
            w_seg_nxt = w_m_valid ? seg7(w_m_ones[3:0]) : SEG_DASH;
            w_dp_nxt  = w_colon_n;
         end
         3'd3: w_seg_nxt = w_m_valid ? seg7(w_m_tens[3:0]) : SEG_DASH;
         3'd4: begin
            w_seg_nxt = w_h_valid ? seg7(w_h_ones[3:0]) : SEG_DASH;
            w_dp_nxt  = w_colon_n;
         end
         3'd5: begin
            if (!w_h_valid) begin
               w_seg_nxt = SEG_DASH;
            end else if (Mode12 && (w_h_tens == 6'd0)) begin
               w_seg_nxt = SEG_BLANK;
            end else begin
               w_seg_nxt = seg7(w_h_tens[3:0]);
            end
         end
         default: begin
            w_seg_nxt = SEG_BLANK;
            w_dp_nxt  = 1'b1;
         end
      endcase
   end

   // Prescaler, digit index, frame snapshot and registered display outputs.
   always_ff @(posedge Clk) begin
      if (Clr) begin
         r_cnt <= '0;
         r_idx <= 3'd0;
         r_h   <= 6'd0;
         r_m   <= 6'd0;
         r_s   <= 6'd0;
         r_seg <= SEG_BLANK;
         r_an  <= 6'h3F;
         r_dp  <= 1'b1;
      end else begin
         if (w_tc) begin
            r_cnt <= '0;
            if (r_idx == 3'd5) begin
               r_idx <= 3'd0;
               r_h   <= H;
               r_m   <= M;
               r_s   <= S;
            end else begin
               r_idx <= r_idx + 3'd1;
            end
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (En) begin
            r_seg <= w_seg_nxt;
            r_an  <= ~(6'b000001 << r_idx);
            r_dp  <= w_dp_nxt;
         end else begin
            r_seg <= SEG_BLANK;
            r_an  <= 6'h3F;
            r_dp  <= 1'b1;
         end
      end
   end

   assign Seg = r_seg;
   assign An  = r_an;
   assign Dp  = r_dp;

endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
- Downstream consumer of the time-of-day counter. Takes the binary hours/minutes/seconds outputs (6 bits each) and drives a 6-digit multiplexed seven-segment display.
- Functions: frame-coherent snapshot, binary-to-BCD split, 12/24-hour formatting, range checking, colon blink, time-multiplexed digit scanning.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays active (minimum 2).
- CNT_W, 16, prescaler width; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- Clk  input  1  system clock, all logic on rising edge.
- Clr  input  1  reset, synchronous, active-high.
- H  input  6  binary hours, valid 0..23.
- M  input  6  binary minutes, valid 0..59.
- S  input  6  binary seconds, valid 0..59.
- Mode12  input  1  1 = 12-hour display, 0 = 24-hour.
- En  input  1  display enable.
- Seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- An  output  6  digit enables, active-low, bit i = digit i.
- Dp  output  1  decimal point of the active digit, active-low.

Behaviour:
- Clock and reset: one clock (Clk). Clr is synchronous and active-high.
- Reset values (at the Clr edge):
  - Seg = 7'h7F, An = 6'h3F, Dp = 1.
  - Prescaler = 0, digit index = 0, shadow H/M/S = 0.
- Digit map:
  - 0 = seconds ones, 1 = seconds tens.
  - 2 = minutes ones, 3 = minutes tens.
  - 4 = hours ones, 5 = hours tens.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps to 0. On the terminal-count cycle the digit index advances 0→1→…→5→0.
- Frame: REFRESH_DIV*6 cycles.
- Snapshot: on the edge where the digit index wraps 5→0, shadow H/M/S load from the inputs. All six digits of one frame come from one snapshot, so input changes mid-frame are not visible until the next frame.
- Output timing: Seg/An/Dp are registered from the digit index and shadow values, one cycle of latency. The index changes at edge k; outputs show the new digit at edge k+1.
- Output timing when not in reset: An = ~(6'b1 << idx) when En=1, 6'h3F when En=0. When En=0, Seg = 7'h7F and Dp = 1, and scanning and snapshots continue.
- BCD: tens = v/10 and ones = v%10 for v in 0..59, built combinationally.
- Hour formatting, 24-hour mode: hours shown 00..23.
- Hour formatting, 12-hour mode:
  - H=0 → 12, PM=0.
  - H=1..11 → H, PM=0.
  - H=12 → 12, PM=1.
  - H=13..23 → H-12, PM=1.
  - Hours tens digit is blank (7'h7F) when it is 0.
- Range check: any field out of range (H>23, M>59 or S>59) shows dash (7'b0111111) on both digits of that field only. For an invalid H, the PM flag is 0 and the tens digit is not blanked.
- Digit encodings (active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001.
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
- Dp:
  - Digits 2 and 4: Dp = 0 (lit, colon) when shadow S[0] = 0, otherwise 1. Dashed seconds also give 1.
  - Digit 0: Dp = 0 when Mode12=1 and PM=1.
  - All other cases: Dp = 1.
- Mode12 and En are sampled each cycle, not snapshotted. Mode12 takes effect on the next output update.
- Reset mid-scan: everything returns to reset values on that edge. The first snapshot after reset occurs at the first 5→0 wrap. Until then the shadow value 00:00:00 is displayed.

Test Plan:
- Reset: Clr=1 for 3 cycles, then Clr=0, with REFRESH_DIV=4 and En=1.
  - During reset: An=3F, Seg=7F, Dp=1.
  - After release: An=3E with Seg=1000000 ("0") one cycle after release.
  - An steps 3E→3D→3B→37→2F→1F every 4 cycles.
- 24-hour, H=23 M=59 S=58, after one wrap:
  - Digits 0..5 show 8,5,9,5,3,2 (0000000, 0010010, 0010000, 0010010, 0110000, 0100100).
  - Dp=0 on digits 2 and 4.
- 12-hour cases:
  - H=0 → digit 5 "1", digit 4 "2", digit 0 Dp=1.
  - H=13 → digit 5 blank (7F), digit 4 "1", digit 0 Dp=0.
  - H=12 → "12", digit 0 Dp=0.
- Coherency: load S=09, then change to S=10 while digit 2 is active. Digits 0/1 in that frame still show 9/0; the next frame shows 0/1.
- Range check, M=60, H=5, S=7:
  - Digits 2/3 show 0111111.
  - Hours show 0/5, seconds show 7/0.
  - Dp on digit 2 is 1 (S odd).
- En and reset mid-scan:
  - En=0 mid-frame → An=3F, Seg=7F from the next cycle, with index still advancing.
  - Clr pulsed while idx=3 → next cycle An=3F, then scanning restarts at digit 0 showing 00:00:00.
